// File: rtl/vga_pkg.sv
// Shared VGA scanout constants: default 640x480@60 timing, pixel width and vgaData bit map.
package vga_pkg;

    // Horizontal timing in pixel clocks
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync active level: 0 gives active-low pulses
    localparam bit SYNC_POL = 1'b0;

    localparam int unsigned FIFO_DEPTH = 16;

    // Pixel is {R[2:0],G[2:0],B[1:0]}
    localparam int unsigned PIX_W = 8;
    localparam int unsigned VGA_W = 10;

    // vgaData bit positions
    localparam int unsigned HS_BIT = 9;
    localparam int unsigned VS_BIT = 8;
    localparam int unsigned R_MSB  = 7;
    localparam int unsigned R_LSB  = 5;
    localparam int unsigned G_MSB  = 4;
    localparam int unsigned G_LSB  = 2;
    localparam int unsigned B_MSB  = 1;
    localparam int unsigned B_LSB  = 0;

    typedef logic [PIX_W-1:0] pix_t;

    // Pin level of a sync signal given whether its pulse is asserted
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO; rdata shows the head entry whenever the FIFO is not empty.
module pix_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Occupancy flags from wrap-bit pointers; writes to a full FIFO are dropped
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset discards contents by emptying the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pixel FIFO plus raster counters, sync decode and registered vgaData output.
module vga_scanout #(
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP       = vga_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP       = vga_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_pkg::V_BP,
    parameter bit          SYNC_POL   = vga_pkg::SYNC_POL,
    parameter int unsigned FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
    input  logic                      cin,
    input  logic                      rst_n,
    input  logic [vga_pkg::PIX_W-1:0] pix_data,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      frame_start,
    output logic                      underflow,
    input  logic                      clr_underflow,
    output logic [vga_pkg::VGA_W-1:0] vgaData
);

    import vga_pkg::*;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [VGA_W-1:0] VGA_RST = {~SYNC_POL, ~SYNC_POL, {PIX_W{1'b0}}};

    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic [VGA_W-1:0] vga_q, vga_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;

    logic             active_c;
    logic             hs_on_c;
    logic             vs_on_c;
    logic             pop_c;
    logic             push_c;
    logic             fifo_full;
    logic             fifo_empty;
    pix_t             fifo_rdata;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_pix_fifo (
        .clk   (cin),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (pix_data),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Producer handshake: accept whenever the FIFO has room
    always_comb begin
        pix_ready = !fifo_full;
        push_c    = pix_valid && !fifo_full;
    end

    // Raster counters: h wraps at end of line and advances v, v wraps at end of frame
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOTAL - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end
    end

    // Decode current raster position into the next output word, pop and underflow
    always_comb begin
        active_c = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
        hs_on_c  = (h_cnt_q >= HW'(HS_START)) && (h_cnt_q < HW'(HS_END));
        vs_on_c  = (v_cnt_q >= VW'(VS_START)) && (v_cnt_q < VW'(VS_END));
        pop_c    = active_c && !fifo_empty;

        vga_d         = '0;
        vga_d[HS_BIT] = sync_level(hs_on_c, SYNC_POL);
        vga_d[VS_BIT] = sync_level(vs_on_c, SYNC_POL);
        if (pop_c) begin
            vga_d[R_MSB:B_LSB] = fifo_rdata;
        end

        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

        // A fresh underflow takes priority over a clear in the same cycle
        underflow_d = underflow_q;
        if (clr_underflow) begin
            underflow_d = 1'b0;
        end
        if (active_c && fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vga_q         <= VGA_RST;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vga_q         <= vga_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vgaData     = vga_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout against a queue-based raster model, using reduced timing.
module tb_vga_scanout;

    localparam int unsigned HA    = 16;
    localparam int unsigned HFP   = 2;
    localparam int unsigned HSW   = 4;
    localparam int unsigned HBP   = 3;
    localparam int unsigned HT    = HA + HFP + HSW + HBP;
    localparam int unsigned VA    = 6;
    localparam int unsigned VFP   = 1;
    localparam int unsigned VSW   = 2;
    localparam int unsigned VBP   = 1;
    localparam int unsigned VT    = VA + VFP + VSW + VBP;
    localparam int unsigned FR    = HT * VT;
    localparam int unsigned DEPTH = 16;

    logic       cin = 1'b0;
    logic       rst_n;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       frame_start;
    logic       underflow;
    logic       clr_underflow;
    logic [9:0] vgaData;

    vga_scanout #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HSW),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VSW),
        .V_BP       (VBP),
        .SYNC_POL   (1'b0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .cin           (cin),
        .rst_n         (rst_n),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .clr_underflow (clr_underflow),
        .vgaData       (vgaData)
    );

    always #5 cin = ~cin;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: cycles since reset release, FIFO contents, sticky flag
    logic [7:0] mq[$];
    int         m_t;
    logic       m_uf;

    int hs_low;
    int vs_low;
    int fs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // One pixel clock: drive inputs after negedge, predict, check 1 time unit after posedge
    task automatic cycle(input logic v, input logic [7:0] d, input logic c, output logic acc);
        int         h;
        int         ln;
        logic       act;
        logic       was_empty;
        logic       exp_ready;
        logic       hs_on;
        logic       vs_on;
        logic       exp_fs;
        logic [7:0] pix;
        logic [9:0] exp_word;

        h  = m_t % HT;
        ln = (m_t / HT) % VT;
        act       = (h < HA) && (ln < VA);
        hs_on     = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs_on     = (ln >= VA + VFP) && (ln < VA + VFP + VSW);
        exp_fs    = (h == 0) && (ln == 0);
        was_empty = (mq.size() == 0);
        exp_ready = (mq.size() < DEPTH);

        pix_valid     = v;
        pix_data      = d;
        clr_underflow = c;
        #1;
        chk("pix_ready", 32'(pix_ready), 32'(exp_ready));

        pix = 8'h00;
        if (act && !was_empty) pix = mq.pop_front();
        if (act && was_empty) m_uf = 1'b1;
        else if (c)           m_uf = 1'b0;
        acc = v && exp_ready;
        if (acc) mq.push_back(d);
        exp_word = {~hs_on, ~vs_on, pix};
        m_t++;

        @(posedge cin);
        #1;
        chk("vgaData", 32'(vgaData), 32'(exp_word));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("underflow", 32'(underflow), 32'(m_uf));
        if (!vgaData[9]) hs_low++;
        if (!vgaData[8]) vs_low++;
        if (frame_start) fs_cnt++;
        @(negedge cin);
    endtask

    // Assert reset (takes effect immediately), hold, release on a falling edge
    task automatic do_reset(input int ncyc);
        rst_n         = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = 8'h00;
        clr_underflow = 1'b0;
        #1;
        chk("rst_vgaData", 32'(vgaData), 32'h300);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        chk("rst_pix_ready", 32'(pix_ready), 32'h1);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge cin);
            #1;
            chk("rst_hold_vgaData", 32'(vgaData), 32'h300);
            chk("rst_hold_frame_start", 32'(frame_start), 32'h0);
        end
        @(negedge cin);
        rst_n = 1'b1;
        mq.delete();
        m_t  = 0;
        m_uf = 1'b0;
    endtask

    initial begin
        logic       acc;
        logic [7:0] ramp;

        rst_n         = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = 8'h00;
        clr_underflow = 1'b0;
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        @(negedge cin);
        do_reset(3);

        // Continuous ramp feed over two whole frames; also tally sync widths
        ramp   = 8'h00;
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            cycle(1'b1, ramp, 1'b0, acc);
            if (acc) ramp++;
        end
        chk("hsync_low_cycles", 32'(hs_low), 32'(2 * VT * HSW));
        chk("vsync_low_cycles", 32'(vs_low), 32'(2 * VSW * HT));
        chk("frame_start_count", 32'(fs_cnt), 32'd2);

        // Random producer rate with occasional clears: underflows and partial fills
        for (int i = 0; i < 4 * FR; i++) begin
            cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 8'($urandom()),
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, acc);
        end

        // Producer stalls mid-line 2 until vertical blanking, then clear in blanking
        while ((m_t % FR) != (2 * HT + 7)) cycle(1'b1, 8'($urandom()), 1'b0, acc);
        while ((m_t % FR) != (VA * HT)) cycle(1'b0, 8'h00, 1'b0, acc);
        chk("underflow_stalled", 32'(underflow), 32'h1);
        cycle(1'b0, 8'h00, 1'b1, acc);
        chk("underflow_cleared", 32'(underflow), 32'h0);

        // Fill past capacity during blanking, then drain through the next frame
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, acc);
        chk("fifo_full_not_ready", 32'(pix_ready), 32'h0);
        for (int i = 0; i < FR; i++) cycle(1'b0, 8'h00, 1'b0, acc);

        // Reset mid-frame in the active area, then restart from (0,0)
        do_reset(0);
        while (m_t != (4 * HT + 10)) cycle(1'b1, 8'($urandom()), 1'b0, acc);
        do_reset(2);
        fs_cnt = 0;
        for (int i = 0; i < FR + 5; i++) begin
            cycle(($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0, 8'($urandom()), 1'b0, acc);
        end
        chk("frame_start_after_reset", 32'(fs_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
